// File: rtl/axis_gearbox.sv
// rtl/axis_gearbox.sv - AXI4-Stream lane gearbox between arbitrary lane-multiple widths
module axis_gearbox #(
  parameter int LANE_WIDTH = 8,
  parameter int S_LANES    = 3,
  parameter int M_LANES    = 4,
  parameter int USER_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [S_LANES*LANE_WIDTH-1:0] s_axis_tdata,
  input  logic [S_LANES-1:0]            s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  output logic [M_LANES*LANE_WIDTH-1:0] m_axis_tdata,
  output logic [M_LANES-1:0]            m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser
);

  localparam int BUF_LANES = S_LANES + M_LANES - 1;
  localparam int CNT_W     = $clog2(BUF_LANES + 1);
  localparam logic [CNT_W-1:0] M_CNT = CNT_W'(M_LANES);

  logic [BUF_LANES*LANE_WIDTH-1:0] buf_q, buf_d;
  logic [USER_WIDTH-1:0]           ubuf_q, ubuf_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            pend_q, pend_d;

  logic             push, pop;
  logic [CNT_W-1:0] k_cnt, p_cnt, base_cnt;

  // Handshake and output fields depend on registers only, so m_axis_tready never reaches s_axis_tready.
  assign s_axis_tready = (cnt_q < M_CNT) && !pend_q;
  assign m_axis_tvalid = (cnt_q >= M_CNT) || pend_q;
  assign m_axis_tdata  = buf_q[M_LANES*LANE_WIDTH-1:0];
  assign m_axis_tlast  = pend_q && (cnt_q <= M_CNT);
  assign m_axis_tuser  = ubuf_q;

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  // Output keep marks the low min(cnt, M_LANES) lanes.
  always_comb begin
    m_axis_tkeep = '0;
    for (int i = 0; i < M_LANES; i++) begin
      m_axis_tkeep[i] = (CNT_W'(i) < cnt_q);
    end
  end

  // Lanes arriving (k), lanes leaving (p) and the slot where new lanes land after the pop shift.
  always_comb begin
    k_cnt = '0;
    for (int i = 0; i < S_LANES; i++) begin
      if (s_axis_tkeep[i]) k_cnt = k_cnt + CNT_W'(1);
    end
    p_cnt    = pop ? ((cnt_q < M_CNT) ? cnt_q : M_CNT) : '0;
    base_cnt = cnt_q - p_cnt;
  end

  // Next buffer: shift out popped lanes, then drop accepted lanes in right behind the survivors.
  always_comb begin
    buf_d = '0;
    for (int j = 0; j < BUF_LANES; j++) begin
      if (j + int'(p_cnt) < BUF_LANES) begin
        buf_d[j*LANE_WIDTH +: LANE_WIDTH] = buf_q[(j + int'(p_cnt))*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    for (int j = 0; j < BUF_LANES; j++) begin
      for (int i = 0; i < S_LANES; i++) begin
        if (push && (i < int'(k_cnt)) && (j == int'(base_cnt) + i)) begin
          buf_d[j*LANE_WIDTH +: LANE_WIDTH] = s_axis_tdata[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Count, packet-end flag and sideband accumulator; tuser accepted alongside a pop belongs to the next word.
  always_comb begin
    cnt_d  = base_cnt + (push ? k_cnt : '0);
    pend_d = pend_q;
    ubuf_d = ubuf_q;
    if (pop && m_axis_tlast) pend_d = 1'b0;
    if (push) pend_d = s_axis_tlast;
    if (pop) begin
      ubuf_d = push ? s_axis_tuser : '0;
    end else if (push) begin
      ubuf_d = ubuf_q | s_axis_tuser;
    end
  end

  // State registers; reset drops any partially assembled word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_q  <= '0;
      ubuf_q <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      ubuf_q <= ubuf_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_axis_gearbox.sv
// tb/tb_axis_gearbox.sv - scoreboard bench for axis_gearbox (3 lanes in, 4 lanes out)
module tb_axis_gearbox;

  localparam int LW = 8;
  localparam int S  = 3;
  localparam int M  = 4;
  localparam int UW = 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic [S*LW-1:0] s_axis_tdata;
  logic [S-1:0]    s_axis_tkeep;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic [UW-1:0]   s_axis_tuser;
  logic [M*LW-1:0] m_axis_tdata;
  logic [M-1:0]    m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [UW-1:0]   m_axis_tuser;

  axis_gearbox #(
    .LANE_WIDTH(LW), .S_LANES(S), .M_LANES(M), .USER_WIDTH(UW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M*LW-1:0] data;
    logic [M-1:0]    keep;
    logic            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [LW-1:0] lane_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Packet model: lanes of a packet fill words densely; a word closes when full, or at packet end.
  task automatic emit(input int n, input logic last);
    exp_t e;
    e.data = '0;
    e.keep = '0;
    e.last = last;
    for (int i = 0; i < n; i++) begin
      e.data[i*LW +: LW] = lane_q.pop_front();
      e.keep[i] = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic model_accept(input logic [S*LW-1:0] d, input int k, input logic last);
    for (int i = 0; i < k; i++) lane_q.push_back(d[i*LW +: LW]);
    if (!last) begin
      while (lane_q.size() >= M) emit(M, 1'b0);
    end else begin
      while (lane_q.size() > M) emit(M, 1'b0);
      emit(lane_q.size(), 1'b1);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat has been taken (or timed out).
  task automatic send_beat(input logic [S*LW-1:0] d, input int k, input logic last, input logic user);
    bit accepted;
    accepted      = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = S'((1 << k) - 1);
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 1000 && !accepted; c++) begin
      @(negedge clk);
      if (rstn && s_axis_tready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    chk("beat_accept_timeout", 64'(accepted), 64'd1);
    if (accepted) model_accept(d, k, last);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'd1);
    chk({tag, "_m_tdata"},  64'(m_axis_tdata),  64'd0);
    chk({tag, "_m_tkeep"},  64'(m_axis_tkeep),  64'd0);
    chk({tag, "_m_tlast"},  64'(m_axis_tlast),  64'd0);
    chk({tag, "_m_tuser"},  64'(m_axis_tuser),  64'd0);
  endtask

  task automatic apply_reset();
    rstn          = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    lane_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 64'(exp_q.size() == 0), 64'd1);
  endtask

  // Output ready pattern: always, alternating, or random.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: every handshake seen at the negedge happens at the coming posedge.
  logic            acc;
  logic            push_now, pop_now, any_last;
  logic [M*LW-1:0] md;
  exp_t            e_mon;

  always @(negedge clk) begin
    if (!rstn) begin
      acc = 1'b0;
    end else begin
      push_now = s_axis_tvalid && s_axis_tready;
      pop_now  = m_axis_tvalid && m_axis_tready;
      if (s_axis_tvalid)
        assert ((s_axis_tkeep & (s_axis_tkeep + S'(1))) == '0) else $error("non-contiguous tkeep driven");
      any_last = 1'b0;
      foreach (exp_q[i]) if (exp_q[i].last) any_last = 1'b1;
      if (any_last) chk("s_tready_blocked_after_tlast", 64'(s_axis_tready), 64'd0);
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output_beat", 64'(m_axis_tdata), 64'd0);
          chk("unexpected_output_present", 64'd1, 64'd0);
        end else begin
          e_mon = exp_q.pop_front();
          md    = m_axis_tdata;
          for (int i = 0; i < M; i++) if (!e_mon.keep[i]) md[i*LW +: LW] = '0;
          chk("m_tdata", 64'(md), 64'(e_mon.data));
          chk("m_tkeep", 64'(m_axis_tkeep), 64'(e_mon.keep));
          chk("m_tlast", 64'(m_axis_tlast), 64'(e_mon.last));
          chk("m_tuser", 64'(m_axis_tuser), 64'(acc));
        end
        acc = push_now ? s_axis_tuser[0] : 1'b0;
      end else if (push_now) begin
        acc = acc | s_axis_tuser[0];
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int              nb, k;
  logic [S*LW-1:0] d;

  initial begin
    rstn          = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Four full beats, lanes 0x00..0x0B, tlast on the fourth.
    send_beat(24'h020100, 3, 1'b0, 1'b0);
    send_beat(24'h050403, 3, 1'b0, 1'b0);
    send_beat(24'h080706, 3, 1'b0, 1'b0);
    send_beat(24'h0B0A09, 3, 1'b1, 1'b0);
    drain();

    // Five lanes with a partial final beat: full word then a one-lane flush.
    send_beat(24'h121110, 3, 1'b0, 1'b0);
    send_beat(24'hEE1413, 2, 1'b1, 1'b0);
    drain();

    // Zero-length packet, then a fresh packet.
    send_beat(24'hABCDEF, 0, 1'b1, 1'b0);
    send_beat(24'h323130, 3, 1'b1, 1'b0);
    drain();

    // Sideband pattern 0,1,0.
    send_beat(24'h424140, 3, 1'b0, 1'b0);
    send_beat(24'h454443, 3, 1'b0, 1'b1);
    send_beat(24'h484746, 3, 1'b1, 1'b0);
    drain();

    // Alternating output ready.
    rdy_mode = 1;
    send_beat(24'h222120, 3, 1'b0, 1'b1);
    send_beat(24'h002423, 2, 1'b1, 1'b0);
    drain();

    // Random traffic with a reset in the middle of packet 500.
    rdy_mode = 2;
    for (int p = 0; p < 1000; p++) begin
      nb = $urandom_range(1, 4);
      if (p == 500) nb = 3;
      for (int b = 0; b < nb; b++) begin
        k = $urandom_range(0, S);
        d = (S*LW)'($urandom);
        if (p == 500 && b == 0) k = S;
        send_beat(d, k, (b == nb - 1), 1'($urandom_range(0, 1)));
        if (p == 500 && b == 0) begin
          apply_reset();
          break;
        end
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("idle_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("idle_s_tready", 64'(s_axis_tready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
